uart_rx_buf: RTL and testbench



---
 rtl/uart_rx_buf_pkg.sv | 14 +
 rtl/uart_rx_buf_if.sv | 24 ++
 rtl/byte_fifo.sv | 51 +++++
 rtl/uart_rx_buf.sv | 152 +++++++++++++++
 tb/tb_uart_rx_buf.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_buf_pkg.sv
// Shared types and constants for the UART receive buffer.
package uart_rx_buf_pkg;

  localparam int unsigned UART_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_buf_if.sv
// Consumer-side handshake and status bundle of the UART receive buffer.
interface uart_rx_buf_if;
  import uart_rx_buf_pkg::*;

  logic [UART_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 overrun;
  logic                 frame_err;
  logic                 err_clr;

  // Receiver side
  modport master (
    output rx_data, rx_valid, overrun, frame_err,
    input  rx_ready, err_clr
  );

  // Consumer side
  modport slave (
    input  rx_data, rx_valid, overrun, frame_err,
    output rx_ready, err_clr
  );

endinterface

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO, depth 2^LOG_DEPTH. A push while full is
// accepted only when a pop happens in the same cycle.
module byte_fifo
  import uart_rx_buf_pkg::*;
#(
  parameter int unsigned LOG_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [UART_BITS-1:0] wdata,
  input  logic                 pop,
  output logic [UART_BITS-1:0] head,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned Depth = 1 << LOG_DEPTH;

  logic [LOG_DEPTH:0]   wr_q, rd_q;
  logic [UART_BITS-1:0] mem_q [Depth];
  logic                 do_push, do_pop;

  // Status flags and gated handshakes
  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[LOG_DEPTH] != rd_q[LOG_DEPTH]) &&
              (wr_q[LOG_DEPTH-1:0] == rd_q[LOG_DEPTH-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    // Masked so the head reads 0 out of reset and when empty
    head    = empty ? '0 : mem_q[rd_q[LOG_DEPTH-1:0]];
  end

  // Read/write pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[LOG_DEPTH-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_buf.sv
// UART 8N1 receiver with FIFO. Optional macro UART_RX_STOP_CHECK_EN: when
// defined, a low stop bit drops the byte, sets frame_err and waits for the
// line to return high; otherwise the stop bit is ignored.
module uart_rx_buf
  import uart_rx_buf_pkg::*;
#(
  parameter int unsigned RECEIVER_PERIOD = 646,
  parameter int unsigned LOG_DEPTH       = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          UART_RX,
  uart_rx_buf_if.master rx_if
);

  localparam int unsigned CntW = $clog2(2 * RECEIVER_PERIOD);
  localparam logic [CntW-1:0] HalfLoad = CntW'(RECEIVER_PERIOD - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(2 * RECEIVER_PERIOD - 1);

  logic [1:0]           sync_q;
  logic                 line;
  uart_rx_state_t       state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [UART_BITS-1:0] shift_q, shift_d;
  logic                 push, set_ferr, tick;
  logic                 fifo_full, fifo_empty, fifo_pop, drop;
  logic                 overrun_q;

  assign line = sync_q[1];
  assign tick = (cnt_q == '0);

  // Two-flop synchronizer, idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], UART_RX};
  end

  // Receiver state, timing counter and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Next-state logic: samples fire when the counter reaches zero
  always_comb begin
    state_d   = state_q;
    cnt_d     = tick ? cnt_q : cnt_q - 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    set_ferr  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!line) begin
          state_d = StStart;
          cnt_d   = HalfLoad;
        end
      end
      StStart: begin
        if (tick) begin
          if (line) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            cnt_d     = FullLoad;
            bit_idx_d = '0;
          end
        end
      end
      StData: begin
        if (tick) begin
          shift_d = {line, shift_q[UART_BITS-1:1]};
          cnt_d   = FullLoad;
          if (bit_idx_q == 3'(UART_BITS - 1)) state_d = StStop;
          else                                bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      StStop: begin
        if (tick) begin
`ifdef UART_RX_STOP_CHECK_EN
          if (line) begin
            push    = 1'b1;
            state_d = StIdle;
          end else begin
            set_ferr = 1'b1;
            state_d  = StWaitHigh;
          end
`else
          push    = 1'b1;
          state_d = StIdle;
`endif
        end
      end
      StWaitHigh: begin
        // Hold off until a held-low break releases
        if (line) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign fifo_pop = rx_if.rx_ready && !fifo_empty;
  assign drop     = push && fifo_full && !fifo_pop;

  byte_fifo #(
    .LOG_DEPTH(LOG_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .wdata(shift_d),
    .pop  (rx_if.rx_ready),
    .head (rx_if.rx_data),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign rx_if.rx_valid = !fifo_empty;

  // Sticky overrun; a new drop beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun_q <= 1'b0;
    else        overrun_q <= (overrun_q && !rx_if.err_clr) || drop;
  end
  assign rx_if.overrun = overrun_q;

`ifdef UART_RX_STOP_CHECK_EN
  logic frame_err_q;

  // Sticky framing error; a new error beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err_q <= 1'b0;
    else        frame_err_q <= (frame_err_q && !rx_if.err_clr) || set_ferr;
  end
  assign rx_if.frame_err = frame_err_q;
`else
  logic unused_ferr;
  assign unused_ferr     = set_ferr;
  assign rx_if.frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_buf.sv
// Directed bench for uart_rx_buf with RECEIVER_PERIOD=4 and LOG_DEPTH=2.
// Stop-bit expectations follow UART_RX_STOP_CHECK_EN.
module tb_uart_rx_buf;
  import uart_rx_buf_pkg::*;

  localparam int unsigned P  = 4;
  localparam int unsigned LD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_rx = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  uart_rx_buf_if bus ();

  uart_rx_buf #(
    .RECEIVER_PERIOD(P),
    .LOG_DEPTH      (LD)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .UART_RX(uart_rx),
    .rx_if  (bus)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start bit plus eight data bits, 2P cycles each
  task automatic send_body(input logic [7:0] d);
    uart_rx = 1'b0;
    tick(2 * P);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      tick(2 * P);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_body(d);
    uart_rx = stop;
    tick(2 * P);
    uart_rx = 1'b1;
    tick(2 * P);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, 8'(bus.rx_valid), 8'h01);
    check({tag, "_data"}, bus.rx_data, exp);
    bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_ready = 1'b0;
    bus.err_clr  = 1'b0;
    tick(3);
    check("rst_valid", 8'(bus.rx_valid), 8'h00);
    check("rst_data", bus.rx_data, 8'h00);
    check("rst_overrun", 8'(bus.overrun), 8'h00);
    check("rst_frame_err", 8'(bus.frame_err), 8'h00);
    rst_n = 1'b1;
    tick(4);

    // Single frame: valid rises 79 cycles after the pin falls
    send_body(8'hA5);
    uart_rx = 1'b1;
    tick(6);
    check("lat_before", 8'(bus.rx_valid), 8'h00);
    tick(1);
    check("lat_valid", 8'(bus.rx_valid), 8'h01);
    check("lat_data", bus.rx_data, 8'hA5);
    bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;
    check("pop_empty", 8'(bus.rx_valid), 8'h00);
    tick(2 * P);

    // Short low glitch is rejected at the start-bit sample
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    tick(20);
    check("glitch_valid", 8'(bus.rx_valid), 8'h00);
    check("glitch_state", 8'(dut.state_q), 8'(StIdle));

    // Overflow: fifth byte dropped
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
    check("ovf_overrun", 8'(bus.overrun), 8'h01);
    check("ovf_frame_err", 8'(bus.frame_err), 8'h00);
    pop_check("ovf_b1", 8'h01);
    pop_check("ovf_b2", 8'h02);
    pop_check("ovf_b3", 8'h03);
    pop_check("ovf_b4", 8'h04);
    check("ovf_drained", 8'(bus.rx_valid), 8'h00);
    check("ovf_sticky", 8'(bus.overrun), 8'h01);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    check("ovf_cleared", 8'(bus.overrun), 8'h00);

    // Push onto a full FIFO with a simultaneous pop is accepted
    for (int b = 1; b <= 4; b++) send_frame(8'(8'h10 + b), 1'b1);
    send_body(8'h15);
    uart_rx = 1'b1;
    tick(6);
    check("full_head", bus.rx_data, 8'h11);
    bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;
    check("full_overrun", 8'(bus.overrun), 8'h00);
    tick(1 + 2 * P);
    pop_check("full_b2", 8'h12);
    pop_check("full_b3", 8'h13);
    pop_check("full_b4", 8'h14);
    pop_check("full_b5", 8'h15);
    check("full_drained", 8'(bus.rx_valid), 8'h00);
    check("full_overrun2", 8'(bus.overrun), 8'h00);

    // Low stop bit on 0x3C
`ifdef UART_RX_STOP_CHECK_EN
    send_body(8'h3C);
    uart_rx = 1'b0;
    tick(2 * P + 40);
    uart_rx = 1'b1;
    tick(20);
    check("ferr_valid", 8'(bus.rx_valid), 8'h00);
    check("ferr_flag", 8'(bus.frame_err), 8'h01);
    check("ferr_state", 8'(dut.state_q), 8'(StIdle));
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    check("ferr_cleared", 8'(bus.frame_err), 8'h00);
`else
    send_frame(8'h3C, 1'b0);
    check("ferr_flag", 8'(bus.frame_err), 8'h00);
    pop_check("ferr_byte", 8'h3C);
    check("ferr_drained", 8'(bus.rx_valid), 8'h00);
`endif

    // Reset mid-DATA with two bytes queued
    send_frame(8'h21, 1'b1);
    send_frame(8'h22, 1'b1);
    check("mid_queued", 8'(bus.rx_valid), 8'h01);
    uart_rx = 1'b0;
    tick(2 * P);
    uart_rx = 1'b1;
    tick(2 * P);
    uart_rx = 1'b0;
    tick(P);
    rst_n = 1'b0;
    #2;
    check("mid_rst_valid", 8'(bus.rx_valid), 8'h00);
    check("mid_rst_data", bus.rx_data, 8'h00);
    tick(1);
    check("mid_rst_next", 8'(bus.rx_valid), 8'h00);
    uart_rx = 1'b1;
    rst_n   = 1'b1;
    tick(20);
    check("mid_idle", 8'(bus.rx_valid), 8'h00);
    send_frame(8'h5A, 1'b1);
    pop_check("mid_5a", 8'h5A);
    check("mid_drained", 8'(bus.rx_valid), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
